// File: rtl/router_pkt_fifo_if.sv
// Handshake bundle between the router register block (master) and one output-port FIFO (slave).
interface router_pkt_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             soft_reset;
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [AW:0]      level;
    logic             pkt_active;
    logic             parity_err;

    modport master (
        output soft_reset, write_enb, lfd_state, data_in, read_enb,
        input  data_out, data_valid, full, empty, almost_full, level, pkt_active, parity_err
    );

    modport slave (
        input  soft_reset, write_enb, lfd_state, data_in, read_enb,
        output data_out, data_valid, full, empty, almost_full, level, pkt_active, parity_err
    );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output port: header-tagged storage, read-side packet tracking.
// Optional read-side parity check enabled by defining ROUTER_FIFO_PARITY_CHK_EN.
module router_pkt_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14
) (
    input logic              clock,
    input logic              resetn,
    router_pkt_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [AW:0]      AF_LVL  = AF_THRESH[AW:0];
    localparam logic [WIDTH-2:0] CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] hdr_flag;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      lvl;
    logic [WIDTH-2:0] rem_cnt;
    logic             hdr_tag;
    logic [WIDTH-1:0] data_out_q;
    logic             data_valid_q;
    logic             flush;
    logic             full_i;
    logic             empty_i;
    logic             wr_accept;
    logic             rd_accept;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic             rd_hdr;

    assign flush     = !resetn || bus.soft_reset;
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign rd_word   = mem[rd_idx];
    assign rd_hdr    = hdr_flag[rd_idx];
    assign full_i    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign empty_i   = (wr_ptr == rd_ptr);
    assign lvl       = wr_ptr - rd_ptr;
    assign wr_accept = bus.write_enb && !full_i;
    assign rd_accept = bus.read_enb && !empty_i;

    assign bus.full        = full_i;
    assign bus.empty       = empty_i;
    assign bus.level       = lvl;
    assign bus.almost_full = (lvl >= AF_LVL);
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.pkt_active  = (rem_cnt != '0);

    // Payload storage is never reset; only the header flags need clearing on flush.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rem_cnt      <= '0;
            hdr_tag      <= 1'b0;
            hdr_flag     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            hdr_tag      <= bus.lfd_state;
            data_valid_q <= rd_accept;
            if (wr_accept) begin
                hdr_flag[wr_idx] <= hdr_tag;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                data_out_q <= rd_word;
                rd_ptr     <= rd_ptr + PTR_ONE;
                // Header length counts payload only; one extra for the trailing parity byte.
                if (rd_hdr) begin
                    rem_cnt <= {1'b0, rd_word[WIDTH-1:2]} + CNT_ONE;
                end else if (rem_cnt != '0) begin
                    rem_cnt <= rem_cnt - CNT_ONE;
                end
            end
        end
    end

`ifdef ROUTER_FIFO_PARITY_CHK_EN
    logic [WIDTH-1:0] acc;
    logic             parity_err_q;

    always_ff @(posedge clock) begin
        if (flush) begin
            acc          <= '0;
            parity_err_q <= 1'b0;
        end else if (rd_accept) begin
            if (rd_hdr) begin
                acc          <= rd_word;
                parity_err_q <= 1'b0;
            end else if (rem_cnt == CNT_ONE) begin
                parity_err_q <= (acc != rd_word);
            end else if (rem_cnt != '0) begin
                acc <= acc ^ rd_word;
            end
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Scoreboard bench for router_pkt_fifo: expected read data queued at issue, checked by a negedge monitor.
module tb_router_pkt_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
`ifdef ROUTER_FIFO_PARITY_CHK_EN
    localparam int PCHK = 1;
`else
    localparam int PCHK = 0;
`endif

    logic clock;
    logic resetn;
    int   tests = 0;
    int   fails = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];

    router_pkt_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    router_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(14)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resetn && bus.data_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got data %0h expected no valid", bus.data_out);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (bus.data_out !== e) begin
                    fails++;
                    $display("FAIL read_data: got %0h expected %0h", bus.data_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d, input bit hdr);
        if (hdr) begin
            bus.lfd_state = 1'b1;
            tick();
            bus.lfd_state = 1'b0;
        end
        bus.write_enb = 1'b1;
        bus.data_in   = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        tick();
        bus.write_enb = 1'b0;
    endtask

    task automatic rd();
        bus.read_enb = 1'b1;
        if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
        tick();
        bus.read_enb = 1'b0;
    endtask

    task automatic both(input logic [WIDTH-1:0] d);
        bit was_full, was_empty;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        bus.read_enb  = 1'b1;
        bus.write_enb = 1'b1;
        bus.data_in   = d;
        if (!was_empty) exp_q.push_back(model_q.pop_front());
        if (!was_full) model_q.push_back(d);
        tick();
        bus.read_enb  = 1'b0;
        bus.write_enb = 1'b0;
    endtask

    task automatic send_pkt(input logic [WIDTH-1:0] par);
        wr(8'h0D, 1'b1);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(par, 1'b0);
    endtask

    initial begin
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = '0;
        bus.read_enb   = 1'b0;
        resetn         = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check("rst_empty", int'(bus.empty), 1);
        check("rst_level", int'(bus.level), 0);
        check("rst_valid", int'(bus.data_valid), 0);

        // T1: reset with data stored and data_out loaded
        wr(8'hA1, 1'b0);
        wr(8'hA2, 1'b0);
        wr(8'hA3, 1'b0);
        rd();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_q.delete();
        check("t1_empty", int'(bus.empty), 1);
        check("t1_level", int'(bus.level), 0);
        check("t1_data_out", int'(bus.data_out), 0);
        check("t1_valid", int'(bus.data_valid), 0);
        check("t1_pkt_active", int'(bus.pkt_active), 0);

        // T2: one packet, len 3, correct parity
        send_pkt(8'h0D);
        check("t2_level", int'(bus.level), 5);
        for (int i = 0; i < 5; i++) begin
            rd();
            check($sformatf("t2_pkt_active_%0d", i), int'(bus.pkt_active), (i < 4) ? 1 : 0);
        end
        check("t2_parity_err", int'(bus.parity_err), 0);
        check("t2_empty", int'(bus.empty), 1);

        // T3: fill, overflow attempt, drain; three rounds to wrap the pointers
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wr(8'(r * 16 + i + 1), 1'b0);
                if (i == 12) check($sformatf("t3_af_lo_%0d", r), int'(bus.almost_full), 0);
                if (i == 13) check($sformatf("t3_af_hi_%0d", r), int'(bus.almost_full), 1);
                if (i == 14) check($sformatf("t3_notfull_%0d", r), int'(bus.full), 0);
            end
            check($sformatf("t3_full_%0d", r), int'(bus.full), 1);
            wr(8'hEE, 1'b0);
            check($sformatf("t3_level_ovf_%0d", r), int'(bus.level), DEPTH);
            for (int i = 0; i < DEPTH; i++) rd();
            check($sformatf("t3_empty_%0d", r), int'(bus.empty), 1);
            check($sformatf("t3_pkt_active_%0d", r), int'(bus.pkt_active), 0);
        end

        // T4: simultaneous read and write at full, empty, and mid level
        for (int i = 0; i < DEPTH; i++) wr(8'(8'h40 + i), 1'b0);
        both(8'hF0);
        check("t4_full_level", int'(bus.level), 15);
        for (int i = 0; i < 15; i++) rd();
        check("t4_drained", int'(bus.empty), 1);
        both(8'h77);
        check("t4_empty_level", int'(bus.level), 1);
        check("t4_empty_valid", int'(bus.data_valid), 0);
        for (int i = 0; i < 4; i++) wr(8'(8'h60 + i), 1'b0);
        check("t4_mid_pre", int'(bus.level), 5);
        both(8'h99);
        check("t4_mid_level", int'(bus.level), 5);
        for (int i = 0; i < 5; i++) rd();
        check("t4_mid_empty", int'(bus.empty), 1);

        // T5: soft reset mid-packet, then a clean packet
        send_pkt(8'h0D);
        wr(8'h55, 1'b0);
        rd();
        rd();
        rd();
        check("t5_pre_level", int'(bus.level), 3);
        check("t5_pre_active", int'(bus.pkt_active), 1);
        bus.soft_reset = 1'b1;
        tick();
        bus.soft_reset = 1'b0;
        model_q.delete();
        check("t5_empty", int'(bus.empty), 1);
        check("t5_level", int'(bus.level), 0);
        check("t5_pkt_active", int'(bus.pkt_active), 0);
        send_pkt(8'h0D);
        for (int i = 0; i < 5; i++) begin
            rd();
            check($sformatf("t5_pkt_active_%0d", i), int'(bus.pkt_active), (i < 4) ? 1 : 0);
        end

        // T6: corrupted parity byte, sticky until the next header read
        send_pkt(8'h0C);
        for (int i = 0; i < 5; i++) rd();
        check("t6_perr_set", int'(bus.parity_err), PCHK);
        tick();
        check("t6_perr_sticky", int'(bus.parity_err), PCHK);
        send_pkt(8'h0D);
        check("t6_perr_hold", int'(bus.parity_err), PCHK);
        rd();
        check("t6_perr_clr_hdr", int'(bus.parity_err), 0);
        for (int i = 0; i < 4; i++) rd();
        check("t6_perr_good", int'(bus.parity_err), 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
